// File: rtl/vga_pkg.sv
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared constants for the VGA plot-port arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package vga_pkg;
  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 7;
  localparam int DEF_C_W = 3;
  localparam int PIX_W   = 15;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic [PIX_W-1:0] PIX_MAX = 15'd32767;
endpackage

`default_nettype wire

// File: rtl/vga_rr_picker.sv
// ============================================================================
// Module   : vga_rr_picker
// Brief    : Combinational round-robin picker; first set req at or after rr_ptr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  int w_dist;
  int w_best_dist;
  int w_win_idx;

  // Distance from the pointer (with wrap) decides priority; smallest wins.
  always_comb begin
    w_dist      = 0;
    w_best_dist = NUM_REQ;
    w_win_idx   = 0;
    winner      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
      if (req[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_win_idx   = i;
      end
    end
    valid = |req;
    for (int i = 0; i < NUM_REQ; i++) begin
      winner[i] = valid && (w_win_idx == i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_plot_arbiter.sv
// ============================================================================
// Module   : vga_plot_arbiter
// Brief    : Round-robin owner of the vga_adapter plot port with a dead cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int C_W     = DEF_C_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*X_W-1:0] req_x,
  input  logic [NUM_REQ*Y_W-1:0] req_y,
  input  logic [NUM_REQ*C_W-1:0] req_colour,
  input  logic [NUM_REQ-1:0]     req_plot,
  input  logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     grant,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [C_W-1:0]         colour,
  output logic                   plot,
  output logic                   busy,
  output logic [PIX_W-1:0]       pix_count
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [1:0]         state_q,     state_d;
  logic [NUM_REQ-1:0] grant_q,     grant_d;
  logic [PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [PIX_W-1:0]   pix_count_q, pix_count_d;

  logic [NUM_REQ-1:0] winner;
  logic               win_valid;
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic [C_W-1:0]     sel_c;
  logic               sel_plot;
  logic               sel_done;
  logic               sel_req;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W-1:0]   ptr_next;
  logic               in_grant;

  vga_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (winner),
    .valid  (win_valid)
  );

  // grant_q is one-hot only in GRANT, so this doubles as the owner mux.
  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_c    = '0;
    sel_plot = 1'b0;
    sel_done = 1'b0;
    sel_req  = 1'b0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_x    = req_x[i*X_W +: X_W];
        sel_y    = req_y[i*Y_W +: Y_W];
        sel_c    = req_colour[i*C_W +: C_W];
        sel_plot = req_plot[i];
        sel_done = req_done[i];
        sel_req  = req[i];
        sel_idx  = PTR_W'(i);
      end
    end
  end

  assign in_grant  = (state_q == GRANT);
  assign x         = in_grant ? sel_x : '0;
  assign y         = in_grant ? sel_y : '0;
  assign colour    = in_grant ? sel_c : '0;
  assign plot      = in_grant & sel_plot;
  assign busy      = (state_q == GRANT) || (state_q == RELEASE);
  assign grant     = grant_q;
  assign pix_count = pix_count_q;
  assign ptr_next  = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    pix_count_d = pix_count_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d     = GRANT;
          grant_d     = winner;
          pix_count_d = '0;
        end
      end
      GRANT: begin
        if (plot && (pix_count_q != PIX_MAX)) begin
          pix_count_d = pix_count_q + PIX_W'(1);
        end
        if (sel_done || !sel_req) begin
          state_d  = RELEASE;
          grant_d  = '0;
          rr_ptr_d = ptr_next;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      pix_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      pix_count_q <= pix_count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
// ============================================================================
// Module   : tb_vga_plot_arbiter
// Brief    : Directed bench for vga_plot_arbiter with a per-cycle reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_plot_arbiter;
  localparam int N   = 3;
  localparam int XW  = 8;
  localparam int YW  = 7;
  localparam int CW  = 3;
  localparam int PMX = 32767;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*XW-1:0] req_x = '0;
  logic [N*YW-1:0] req_y = '0;
  logic [N*CW-1:0] req_colour = '0;
  logic [N-1:0]    req_plot = '0;
  logic [N-1:0]    req_done = '0;
  logic [N-1:0]    grant;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [CW-1:0]   colour;
  logic            plot;
  logic            busy;
  logic [14:0]     pix_count;

  int total = 0;
  int bad   = 0;

  vga_plot_arbiter #(.NUM_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW)) dut (
    .clock(clock), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .req_plot(req_plot), .req_done(req_done),
    .grant(grant), .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
    .pix_count(pix_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 none), phase 0 idle / 1 owned / 2 dead cycle.
  int m_owner = -1;
  int m_phase = 0;
  int m_ptr   = 0;
  int m_pix   = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_owner = -1; m_phase = 0; m_ptr = 0; m_pix = 0;
    end else if (m_phase == 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_phase == 0 && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N; m_phase = 1; m_pix = 0;
        end
      end
    end else if (m_phase == 1) begin
      if (req_plot[m_owner] && m_pix < PMX) m_pix++;
      if (req_done[m_owner] || !req[m_owner]) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clock) begin
    int ex, ey, ec, ep, eg;
    ex = 0; ey = 0; ec = 0; ep = 0; eg = 0;
    if (m_phase == 1) begin
      eg = 1 << m_owner;
      ex = req_x[m_owner*XW +: XW];
      ey = req_y[m_owner*YW +: YW];
      ec = req_colour[m_owner*CW +: CW];
      ep = req_plot[m_owner];
    end
    check("cyc_grant", grant, eg);
    check("cyc_x", x, ex);
    check("cyc_y", y, ey);
    check("cyc_colour", colour, ec);
    check("cyc_plot", plot, ep);
    check("cyc_busy", busy, (m_phase != 0));
    check("cyc_pix", pix_count, m_pix);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_grant(input string name, input logic [N-1:0] exp);
    for (int k = 0; k < 10 && grant == '0; k++) step();
    #1;
    check(name, grant, exp);
  endtask

  task automatic set_fields(input int i, input int fx, input int fy, input int fc);
    req_x[i*XW +: XW]      = XW'(fx);
    req_y[i*YW +: YW]      = YW'(fy);
    req_colour[i*CW +: CW] = CW'(fc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_fields(1, 33, 44, 2);
    set_fields(2, 159, 119, 7);
    step(); step();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_pix", pix_count, 0);
    reset = 1'b0;
    step();
    req = 3'b001;
    step();
    check("first_grant", grant, 3'b001);
    set_fields(0, 10, 20, 3'b100);
    req_plot = 3'b001;
    #1;
    check("first_x", x, 10);
    check("first_y", y, 20);
    check("first_colour", colour, 4);
    check("first_plot", plot, 1);
    step();
    req_plot = 3'b010;
    #1;
    check("other_plot_ignored", plot, 0);
    check("other_x_kept", x, 10);
    repeat (4) begin step(); req_plot = 3'b011; end
    step();
    req_plot = 3'b001; req_done = 3'b001;
    #1;
    check("done_plot", plot, 1);
    step();
    req = '0; req_done = '0; req_plot = '0;
    #1;
    check("pix_six", pix_count, 6);
    check("rel_grant", grant, 0);
    check("rel_busy", busy, 1);
    step();
    check("idle_busy", busy, 0);
    check("idle_pix_hold", pix_count, 6);

    reset = 1'b1; step(); reset = 1'b0;
    req = 3'b111; req_plot = 3'b111;
    for (int r = 0; r < 4; r++) begin
      logic [N-1:0] seq [4];
      seq = '{3'b001, 3'b010, 3'b100, 3'b001};
      wait_grant("rr_order", seq[r]);
      req_done = grant;
      step();
      req_done = '0;
      check("handover_grant", grant, 0);
      check("handover_plot", plot, 0);
    end
    wait_grant("after_wrap", 3'b010);
    req_done = 3'b010; step(); req_done = '0;
    wait_grant("owner_two", 3'b100);
    req = 3'b011;
    step();
    check("drop_release", grant, 0);
    check("drop_busy", busy, 1);
    wait_grant("ptr_wrapped", 3'b001);
    req_done = 3'b001; step(); req_done = '0;
    wait_grant("owner_one", 3'b010);
    req_plot = 3'b010;
    step(); step(); step();
    reset = 1'b1;
    #1;
    check("async_grant", grant, 0);
    check("async_plot", plot, 0);
    check("async_busy", busy, 0);
    check("async_pix", pix_count, 0);
    step();
    reset = 1'b0;
    req_plot = 3'b001;
    wait_grant("post_reset_idx0", 3'b001);
    repeat (32770) step();
    check("pix_saturate", pix_count, PMX);
    req_done = 3'b001;
    step();
    req_done = '0; req = '0; req_plot = '0;
    check("sat_rel_pix", pix_count, PMX);
    step();
    check("sat_idle_pix", pix_count, PMX);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of screen-drawer requesters (splash, victory, death); legal range 2..8.
REQ-002 Parameter X_W, default 8: pixel x width for 160x120 resolution.
REQ-003 Parameter Y_W, default 7: pixel y width.
REQ-004 Parameter C_W, default 3: colour width (3 bits per pixel).
REQ-005 Port clock, input, 1: single clock, CLOCK_50 domain; one clock only.
REQ-006 Port reset, input, 1: reset, asynchronous, active-high.
REQ-007 Port req, input, NUM_REQ: per-requester access request, level.
REQ-008 Port req_x, input, NUM_REQ*X_W: packed x, requester i in bits [i*X_W +: X_W].
REQ-009 Port req_y, input, NUM_REQ*Y_W: packed y, same packing.
REQ-010 Port req_colour, input, NUM_REQ*C_W: packed colour, same packing.
REQ-011 Port req_plot, input, NUM_REQ: per-requester pixel write strobe.
REQ-012 Port req_done, input, NUM_REQ: per-requester one-cycle screen-complete pulse.
REQ-013 Port grant, output, NUM_REQ: one-hot or zero ownership of the VGA plot port.
REQ-014 Port x, output, X_W; y, output, Y_W; colour, output, C_W; plot, output, 1: drive vga_adapter x/y/colour/plot.
REQ-015 Port busy, output, 1: high in GRANT and RELEASE.
REQ-016 Port pix_count, output, 15: pixels written in the current or most recent grant.

Function
REQ-017 FSM states: IDLE, GRANT, RELEASE; registered state, grant, rr_ptr, pix_count.
REQ-018 IDLE: if any req bit is high at cycle n, winner = first set req index scanning rr_ptr, rr_ptr+1, ... with wrap from NUM_REQ-1 to 0; grant one-hot for winner from cycle n+1; state GRANT.
REQ-019 IDLE with req all-zero: stays IDLE; grant 0.
REQ-020 GRANT: x/y/colour combinationally equal granted requester's fields; plot = req_plot[g]; same-cycle, zero latency.
REQ-021 Outside GRANT, or for non-granted requesters: x=0, y=0, colour=0, plot=0; their req_plot/req_done ignored.
REQ-022 GRANT exits when req_done[g]=1 or req[g]=0: next cycle state RELEASE, grant=0, rr_ptr = (g+1) mod NUM_REQ.
REQ-023 req_done[g] and req_plot[g] in the same cycle: that pixel is driven (plot=1) and counted.
REQ-024 RELEASE: exactly one cycle, plot=0, grant=0, then IDLE; guaranteed dead cycle between owners.
REQ-025 pix_count: cleared to 0 on the IDLE->GRANT transition; +1 on each GRANT cycle with plot=1; saturates at 32767; holds value through RELEASE/IDLE.
REQ-026 A requester still requesting after its grant ends rearbitrates normally; round-robin gives others priority.
REQ-027 grant never has more than one bit set.

Reset
REQ-028 reset asserted: immediately (asynchronously) state=IDLE, grant=0, rr_ptr=0, pix_count=0, plot=0, x/y/colour=0, busy=0.
REQ-029 reset mid-GRANT aborts the grant with no RELEASE cycle; first arbitration after release of reset starts from index 0.

Structure
REQ-030 Shared package vga_pkg holds state encodings (IDLE=0, GRANT=1, RELEASE=2, 2-bit), default X_W/Y_W/C_W, and PIX_MAX=32767.
REQ-031 One combinational sub-module vga_rr_picker: inputs req and rr_ptr, outputs one-hot winner and valid.

Verification
REQ-032 Reset, then req=3'b001 -> grant=3'b001 one cycle later; req_plot[0]=1 with x=10, y=20, colour=3'b100 -> x=10, y=20, colour=4, plot=1 same cycle.
REQ-033 req=3'b111 from IDLE after reset -> grants in order 001, 010, 100, 001 as each owner pulses done; each handover has one RELEASE cycle with plot=0.
REQ-034 Owner 0 plots 5 pixels, then done with plot high -> pix_count=6; req_plot[1]=1 during owner 0 grant -> no effect on plot.
REQ-035 Grant 2, drop req[2] without done -> RELEASE next cycle, rr_ptr wraps to 0.
REQ-036 Assert reset mid-grant with plot high -> grant, plot, busy, pix_count 0 in the same cycle without a clock edge.
REQ-037 Hold plot for 32770 cycles -> pix_count saturates at 32767.
